nmr_scan_scheduler: RTL and testbench
=====================================

NMR_SCAN_SCHEDULER -- requirements
Module: nmr_scan_scheduler

Interface
REQ-001 SHALL have parameter SCAN_WIDTH, default 16, width of the scan count and scan index.
REQ-002 SHALL have parameter TR_WIDTH, default 32, width of the repetition-delay count in CLK cycles.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports named CLK and RST.
REQ-004 CLK  input  1  system clock; all state changes on rising edge.
REQ-005 RST  input  1  asynchronous active-high reset.
REQ-006 GO  input  1  level request from host to run a multi-scan acquisition.
REQ-007 ABORT  input  1  level request to terminate the acquisition in progress.
REQ-008 NUM_SCAN  input  SCAN_WIDTH  number of scans; sampled only on GO acceptance.
REQ-009 TR_DLY  input  TR_WIDTH  repetition delay in cycles; sampled only on GO acceptance.
REQ-010 STR_START  output  1  START to the bit streamer.
REQ-011 STR_DONE  input  1  DONE from the bit streamer.
REQ-012 STR_RST  output  1  one-cycle reset pulse to the bit streamer.
REQ-013 ACQ_TRIG  output  1  one-cycle pulse marking each scan start, for the ADC capture path.
REQ-014 SCAN_IDX  output  SCAN_WIDTH  number of completed scans.
REQ-015 BUSY, ALL_DONE, ABORTED  output  1 each  status flags.

Function
REQ-016 States: IDLE, SRST, RUN, TR, FIN; all outputs registered.
REQ-017 IDLE: GO=1 at edge k -> latch NUM_SCAN, TR_DLY; SCAN_IDX<=0; BUSY<=1; if NUM_SCAN=0 -> FIN, ALL_DONE<=1, BUSY<=0, no STR_RST/STR_START ever; else -> SRST, STR_RST<=1.
REQ-018 SRST lasts exactly one cycle: at next edge STR_RST<=0, STR_START<=1, ACQ_TRIG<=1, -> RUN; GO-to-STR_START latency is 2 edges.
REQ-019 ACQ_TRIG SHALL be high exactly one cycle per scan; cleared at the edge after it is set.
REQ-020 RUN: STR_START held high until STR_DONE sampled high at edge m; then STR_START<=0, SCAN_IDX<=SCAN_IDX+1.
REQ-021 At edge m, if SCAN_IDX+1 = latched NUM_SCAN -> FIN, ALL_DONE<=1, BUSY<=0.
REQ-022 Otherwise, if TR_DLY=0 -> SRST with STR_RST<=1 at edge m; else -> TR, counter loaded with TR_DLY.
REQ-023 TR: counter decrements each edge; when counter=1 -> SRST, STR_RST<=1; STR_RST of the next scan SHALL assert at edge m+TR_DLY.
REQ-024 STR_RST precedes every scan, because the bit streamer clears its DONE only on reset.
REQ-025 ABORT sampled high in SRST, RUN or TR -> STR_START<=0, STR_RST<=1 for one cycle, ABORTED<=1, ALL_DONE<=1, BUSY<=0, -> FIN; SCAN_IDX frozen.
REQ-026 ABORT SHALL take priority over STR_DONE sampled at the same edge; that scan is not counted.
REQ-027 ABORT in IDLE or FIN SHALL be ignored.
REQ-028 GO deasserted during SRST/RUN/TR SHALL be ignored; acquisition continues.
REQ-029 FIN: ALL_DONE and ABORTED held; STR_RST<=0; GO=0 -> IDLE, ALL_DONE<=0, ABORTED<=0; SCAN_IDX holds until next GO.
REQ-030 Counter arithmetic unsigned; SCAN_IDX SHALL never exceed latched NUM_SCAN; NUM_SCAN = 2^SCAN_WIDTH-1 runs without wrap.
REQ-031 STR_DONE outside RUN SHALL be ignored.

Reset
REQ-032 RST=1 -> immediately IDLE; STR_START, STR_RST, ACQ_TRIG, BUSY, ALL_DONE, ABORTED = 0; SCAN_IDX = 0; TR counter = 0.
REQ-033 RST mid-scan SHALL drop STR_START asynchronously; GO held high after RST release starts a new acquisition.

Verification
REQ-034 NUM_SCAN=3, TR_DLY=10, streamer model DONE 50 cycles after START -> 3 STR_RST and 3 ACQ_TRIG pulses, STR_RST exactly 10 edges after each DONE edge, SCAN_IDX=3, ALL_DONE=1, ABORTED=0.
REQ-035 NUM_SCAN=0, GO=1 -> ALL_DONE=1 one edge later, STR_START and STR_RST never asserted.
REQ-036 NUM_SCAN=2, TR_DLY=0 -> STR_RST at the same edge STR_START drops; gap DONE-to-next STR_START = 1 cycle.
REQ-037 NUM_SCAN=5, ABORT during scan 2 RUN, same edge as STR_DONE -> SCAN_IDX=1, ABORTED=1, one STR_RST pulse, STR_START=0.
REQ-038 RST pulse in TR of scan 1 -> all outputs 0 asynchronously; GO held -> fresh run with SCAN_IDX from 0.
REQ-039 GO held high in FIN -> ALL_DONE stays 1, no restart until GO=0 then GO=1.

Source files
------------

// File: rtl/nmr_scan_scheduler.sv
// nmr_scan_scheduler: sequences a multi-scan NMR acquisition.
// Every scan is preceded by a one-cycle streamer reset, then the streamer is
// started and held until it reports DONE. Scans are separated by a
// programmable repetition delay. All outputs are registered.
module nmr_scan_scheduler #(
    parameter int SCAN_WIDTH = 16,
    parameter int TR_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  GO,
    input  logic                  ABORT,
    input  logic [SCAN_WIDTH-1:0] NUM_SCAN,
    input  logic [TR_WIDTH-1:0]   TR_DLY,
    output logic                  STR_START,
    input  logic                  STR_DONE,
    output logic                  STR_RST,
    output logic                  ACQ_TRIG,
    output logic [SCAN_WIDTH-1:0] SCAN_IDX,
    output logic                  BUSY,
    output logic                  ALL_DONE,
    output logic                  ABORTED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SRST,
        S_RUN,
        S_TR,
        S_FIN
    } state_t;

    localparam logic [TR_WIDTH-1:0]   TR_ONE  = {{(TR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SCAN_WIDTH:0]   IDX_ONE = {{SCAN_WIDTH{1'b0}}, 1'b1};

    state_t                state_reg, state_next;
    logic [SCAN_WIDTH-1:0] num_reg, num_next;
    logic [TR_WIDTH-1:0]   tr_reg, tr_next;
    logic [TR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [SCAN_WIDTH-1:0] idx_reg, idx_next;
    logic                  start_reg, start_next;
    logic                  srst_reg, srst_next;
    logic                  trig_reg, trig_next;
    logic                  busy_reg, busy_next;
    logic                  done_reg, done_next;
    logic                  abort_reg, abort_next;

    // One bit wider so the last-scan comparison can never wrap, even when
    // NUM_SCAN is all ones.
    logic [SCAN_WIDTH:0]   idx_inc;
    assign idx_inc = {1'b0, idx_reg} + IDX_ONE;

    // State and output registers; reset drops every output immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
            num_reg   <= '0;
            tr_reg    <= '0;
            cnt_reg   <= '0;
            idx_reg   <= '0;
            start_reg <= 1'b0;
            srst_reg  <= 1'b0;
            trig_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            num_reg   <= num_next;
            tr_reg    <= tr_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            start_reg <= start_next;
            srst_reg  <= srst_next;
            trig_reg  <= trig_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            abort_reg <= abort_next;
        end
    end

    // Next-state and next-output logic; ACQ_TRIG defaults low so it is a single-cycle pulse.
    always_comb begin
        state_next = state_reg;
        num_next   = num_reg;
        tr_next    = tr_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        start_next = start_reg;
        srst_next  = srst_reg;
        trig_next  = 1'b0;
        busy_next  = busy_reg;
        done_next  = done_reg;
        abort_next = abort_reg;

        case (state_reg)
            S_IDLE: begin
                if (GO) begin
                    num_next = NUM_SCAN;
                    tr_next  = TR_DLY;
                    idx_next = '0;
                    if (NUM_SCAN == '0) begin
                        state_next = S_FIN;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = S_SRST;
                        srst_next  = 1'b1;
                        busy_next  = 1'b1;
                    end
                end
            end
            S_SRST, S_RUN, S_TR: begin
                if (ABORT) begin
                    // Abort wins over a simultaneous DONE: that scan is not counted.
                    state_next = S_FIN;
                    start_next = 1'b0;
                    srst_next  = 1'b1;
                    abort_next = 1'b1;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                end else if (state_reg == S_SRST) begin
                    state_next = S_RUN;
                    srst_next  = 1'b0;
                    start_next = 1'b1;
                    trig_next  = 1'b1;
                end else if (state_reg == S_RUN) begin
                    if (STR_DONE) begin
                        start_next = 1'b0;
                        idx_next   = idx_inc[SCAN_WIDTH-1:0];
                        if (idx_inc == {1'b0, num_reg}) begin
                            state_next = S_FIN;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                        end else if (tr_reg == '0) begin
                            state_next = S_SRST;
                            srst_next  = 1'b1;
                        end else begin
                            state_next = S_TR;
                            cnt_next   = tr_reg;
                        end
                    end
                end else begin
                    // Repetition delay: the next streamer reset lands TR_DLY edges after DONE.
                    cnt_next = cnt_reg - TR_ONE;
                    if (cnt_reg == TR_ONE) begin
                        state_next = S_SRST;
                        srst_next  = 1'b1;
                    end
                end
            end
            S_FIN: begin
                srst_next = 1'b0;
                if (!GO) begin
                    state_next = S_IDLE;
                    done_next  = 1'b0;
                    abort_next = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign STR_START = start_reg;
    assign STR_RST   = srst_reg;
    assign ACQ_TRIG  = trig_reg;
    assign SCAN_IDX  = idx_reg;
    assign BUSY      = busy_reg;
    assign ALL_DONE  = done_reg;
    assign ABORTED   = abort_reg;

endmodule

// File: tb/tb_nmr_scan_scheduler.sv
// Testbench for nmr_scan_scheduler: table of acquisition scenarios with a
// streamer model and an STR_RST timing scoreboard, plus hand-written
// sequences for FIN hold, mid-run reset and abort.
module tb_nmr_scan_scheduler;

    localparam int SW = 16;
    localparam int TW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          abort = 1'b0;
    logic          str_done = 1'b0;
    logic [SW-1:0] num_scan = '0;
    logic [TW-1:0] tr_dly = '0;
    logic          str_start, str_rst, acq_trig, busy, all_done, aborted;
    logic [SW-1:0] scan_idx;

    nmr_scan_scheduler #(.SCAN_WIDTH(SW), .TR_WIDTH(TW)) dut (
        .CLK      (clk),
        .RST      (rst),
        .GO       (go),
        .ABORT    (abort),
        .NUM_SCAN (num_scan),
        .TR_DLY   (tr_dly),
        .STR_START(str_start),
        .STR_DONE (str_done),
        .STR_RST  (str_rst),
        .ACQ_TRIG (acq_trig),
        .SCAN_IDX (scan_idx),
        .BUSY     (busy),
        .ALL_DONE (all_done),
        .ABORTED  (aborted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int num;
        int tr;
        int lat;
        int exp_rst;
        int exp_trig;
        int exp_idx;
        int exp_done;
        int exp_abort;
    } row_t;
    row_t rows[5];

    // Scoreboard of edge numbers at which STR_RST must rise.
    int   sb_q[$];
    bit   sb_en = 1'b0;
    int   cur_num = 0, cur_tr = 0, lat = 1;
    int   done_cnt = 0, rst_pulses = 0, trig_pulses = 0, trig_wide = 0;
    int   last_rst_edge = 0, scnt = 0;
    logic prev_rst = 1'b0, prev_start = 1'b0, prev_trig = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs_zero"},
              longint'({str_start, str_rst, acq_trig, busy, all_done, aborted, scan_idx}), 0);
    endtask

    task automatic wait_done(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            if (all_done) break;
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        @(negedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor + bit-streamer model, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (str_rst && !prev_rst) begin
                rst_pulses++;
                last_rst_edge = edge_cnt;
                if (sb_en) begin
                    check("rst_while_start", str_start, 0);
                    if (sb_q.size() == 0) begin
                        check("rst_unexpected", edge_cnt, -1);
                    end else begin
                        check("rst_edge", edge_cnt, sb_q.pop_front());
                    end
                end
            end
            if (str_start && !prev_start && sb_en)
                check("start_latency", edge_cnt, last_rst_edge + 1);
            if (acq_trig && !prev_trig) trig_pulses++;
            if (acq_trig && prev_trig) trig_wide++;
            // Streamer: DONE rises lat cycles into START, cleared only by reset.
            if (rst || str_rst) begin
                str_done = 1'b0;
                scnt = 0;
            end else if (str_start) begin
                scnt++;
                if (scnt >= lat && !str_done) begin
                    str_done = 1'b1;
                    done_cnt++;
                    if (sb_en && done_cnt < cur_num)
                        sb_q.push_back(edge_cnt + 1 + cur_tr);
                end
            end
            prev_rst   = str_rst;
            prev_start = str_start;
            prev_trig  = acq_trig;
        end
    end

    task automatic run_row(input row_t r, input int idx);
        int go_edge;
        int done_edge;
        string tag;
        tag = $sformatf("row%0d", idx);
        pulse_reset(tag);
        num_scan = SW'(r.num);
        tr_dly = TW'(r.tr);
        lat = r.lat;
        cur_num = r.num;
        cur_tr = r.tr;
        done_cnt = 0;
        rst_pulses = 0;
        trig_pulses = 0;
        trig_wide = 0;
        sb_q.delete();
        sb_en = 1'b1;
        @(negedge clk); #1;
        go = 1'b1;
        go_edge = edge_cnt;
        if (r.num != 0) sb_q.push_back(edge_cnt + 1);
        done_edge = -1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            // Inputs change after acceptance; only the latched values matter.
            num_scan = 16'd7;
            tr_dly = 32'd2;
            if (all_done) begin
                done_edge = edge_cnt;
                break;
            end
        end
        check({tag, "_scan_idx"}, scan_idx, r.exp_idx);
        check({tag, "_all_done"}, all_done, r.exp_done);
        check({tag, "_aborted"}, aborted, r.exp_abort);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_str_start"}, str_start, 0);
        check({tag, "_rst_pulses"}, rst_pulses, r.exp_rst);
        check({tag, "_trig_pulses"}, trig_pulses, r.exp_trig);
        check({tag, "_trig_width"}, trig_wide, 0);
        check({tag, "_sb_drain"}, sb_q.size(), 0);
        if (r.num == 0) check({tag, "_zero_latency"}, done_edge - go_edge, 1);
        $display("%s num=%0d tr=%0d lat=%0d idx=%0d rst=%0d trig=%0d", tag, r.num, r.tr,
                 r.lat, scan_idx, rst_pulses, trig_pulses);
        sb_en = 1'b0;
        go = 1'b0;
        @(negedge clk); #1;
        check({tag, "_fin_exit"}, all_done, 0);
    endtask

    initial begin
        int base;
        logic was_done;
        rows[0] = '{num: 3, tr: 10, lat: 50, exp_rst: 3, exp_trig: 3, exp_idx: 3, exp_done: 1, exp_abort: 0};
        rows[1] = '{num: 0, tr: 5,  lat: 10, exp_rst: 0, exp_trig: 0, exp_idx: 0, exp_done: 1, exp_abort: 0};
        rows[2] = '{num: 2, tr: 0,  lat: 7,  exp_rst: 2, exp_trig: 2, exp_idx: 2, exp_done: 1, exp_abort: 0};
        rows[3] = '{num: 1, tr: 1,  lat: 3,  exp_rst: 1, exp_trig: 1, exp_idx: 1, exp_done: 1, exp_abort: 0};
        rows[4] = '{num: 4, tr: 3,  lat: 1,  exp_rst: 4, exp_trig: 4, exp_idx: 4, exp_done: 1, exp_abort: 0};

        repeat (2) @(negedge clk);
        #1;
        check_all_zero("por");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_row(rows[i], i);

        // GO held in FIN: no restart until GO drops and rises again.
        pulse_reset("fin_hold");
        num_scan = 16'd1; tr_dly = 32'd0; lat = 2;
        @(negedge clk); #1;
        go = 1'b1;
        wait_done(500);
        check("fin_hold_done", all_done, 1);
        base = rst_pulses;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("fin_hold_all_done", all_done, 1);
            check("fin_hold_busy", busy, 0);
        end
        check("fin_hold_no_restart", rst_pulses - base, 0);
        go = 1'b0;
        @(negedge clk); #1;
        check("fin_release_done", all_done, 0);
        go = 1'b1;
        @(negedge clk); #1;
        check("restart_str_rst", str_rst, 1);
        check("restart_busy", busy, 1);
        wait_done(500);
        $display("fin_hold idx=%0d done=%0d", scan_idx, all_done);
        go = 1'b0;
        @(negedge clk);

        // Asynchronous reset during the repetition delay of scan 1.
        pulse_reset("tr_rst");
        num_scan = 16'd3; tr_dly = 32'd10; lat = 4;
        @(negedge clk); #1;
        go = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (scan_idx == 1 && busy && !str_start && !str_rst) break;
        end
        check("tr_rst_in_tr", scan_idx, 1);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("tr_rst_async");
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check("tr_rst_restart_rst", str_rst, 1);
        check("tr_rst_restart_idx", scan_idx, 0);
        check("tr_rst_restart_busy", busy, 1);
        wait_done(2000);
        check("tr_rst_final_idx", scan_idx, 3);
        check("tr_rst_final_aborted", aborted, 0);
        $display("tr_rst idx=%0d done=%0d", scan_idx, all_done);
        go = 1'b0;
        @(negedge clk);

        // Abort on the same edge as DONE of scan 2.
        pulse_reset("abort");
        num_scan = 16'd5; tr_dly = 32'd3; lat = 20;
        @(negedge clk); #1;
        go = 1'b1;
        was_done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (str_done && !was_done && scan_idx == 1) break;
            was_done = str_done;
        end
        abort = 1'b1;
        base = rst_pulses;
        @(negedge clk); #1;
        abort = 1'b0;
        check("abort_idx", scan_idx, 1);
        check("abort_aborted", aborted, 1);
        check("abort_all_done", all_done, 1);
        check("abort_busy", busy, 0);
        check("abort_str_start", str_start, 0);
        check("abort_str_rst", str_rst, 1);
        @(negedge clk); #1;
        check("abort_str_rst_clear", str_rst, 0);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        abort = 1'b0;
        check("abort_fin_ignored", aborted, 1);
        check("abort_rst_pulses", rst_pulses - base, 1);
        go = 1'b0;
        @(negedge clk); #1;
        check("abort_idle_aborted", aborted, 0);
        check("abort_idle_all_done", all_done, 0);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("abort_idle_ignored", {busy, aborted, str_rst}, 0);
        abort = 1'b0;
        $display("abort idx=%0d rst_pulses=%0d", scan_idx, rst_pulses - base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
